// File: rtl/ysyx_25030093_mem_arb.sv
`default_nettype none
// ============================================================================
// ysyx_25030093_mem_arb : IFU/LSU arbiter onto a one-outstanding memory port
// Macro YSYX_25030093_ARB_RR_EN selects round-robin instead of LSU priority.
// Rev 1.0
// ============================================================================
module ysyx_25030093_mem_arb #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        ifu_req_valid_i,
  output logic        ifu_req_ready_o,
  input  logic [31:0] ifu_addr_i,
  output logic        ifu_resp_valid_o,
  output logic [31:0] ifu_rdata_o,
  output logic        ifu_resp_err_o,
  input  logic        lsu_req_valid_i,
  output logic        lsu_req_ready_o,
  input  logic [31:0] lsu_addr_i,
  input  logic        lsu_wen_i,
  input  logic [31:0] lsu_wdata_i,
  input  logic [3:0]  lsu_wmask_i,
  output logic        lsu_resp_valid_o,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_resp_err_o,
  output logic        mem_req_valid_o,
  input  logic        mem_req_ready_i,
  output logic [31:0] mem_addr_o,
  output logic        mem_wen_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wmask_o,
  input  logic        mem_resp_valid_i,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_e;

  // Counter value in the cycle where its increment reaches TIMEOUT_CYC.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        owner_lsu_q, owner_lsu_d;
  logic [31:0] addr_q, addr_d;
  logic        wen_q, wen_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wmask_q, wmask_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        grant_lsu;
  logic        accept;
  logic        timeout;

  assign accept  = rst_ni && (state_q == S_IDLE) && (ifu_req_valid_i || lsu_req_valid_i);
  assign timeout = (cnt_q == TO_LAST);

`ifdef YSYX_25030093_ARB_RR_EN
  logic last_lsu_q, last_lsu_d;

  always_comb begin
    if (ifu_req_valid_i && lsu_req_valid_i) grant_lsu = !last_lsu_q;
    else                                    grant_lsu = lsu_req_valid_i;
  end

  always_comb begin
    last_lsu_d = last_lsu_q;
    if (accept) last_lsu_d = grant_lsu;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) last_lsu_q <= 1'b1;
    else         last_lsu_q <= last_lsu_d;
  end
`else
  assign grant_lsu = lsu_req_valid_i;
`endif

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    owner_lsu_d     = owner_lsu_q;
    addr_d          = addr_q;
    wen_d           = wen_q;
    wdata_d         = wdata_q;
    wmask_d         = wmask_q;
    rdata_d         = rdata_q;
    err_d           = err_q;
    mem_req_valid_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          owner_lsu_d = grant_lsu;
          addr_d      = grant_lsu ? lsu_addr_i  : ifu_addr_i;
          wen_d       = grant_lsu && lsu_wen_i;
          wdata_d     = grant_lsu ? lsu_wdata_i : 32'd0;
          wmask_d     = grant_lsu ? lsu_wmask_i : 4'd0;
          cnt_d       = 8'd0;
          state_d     = S_REQ;
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + 8'd1;
        // On the timeout cycle the request is withdrawn so no handshake can slip in.
        if (timeout) begin
          rdata_d = 32'd0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          mem_req_valid_o = 1'b1;
          if (mem_req_ready_i) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (mem_resp_valid_i) begin
          rdata_d = mem_rdata_i;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (timeout) begin
          rdata_d = 32'd0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      owner_lsu_q <= 1'b0;
      addr_q      <= 32'd0;
      wen_q       <= 1'b0;
      wdata_q     <= 32'd0;
      wmask_q     <= 4'd0;
      rdata_q     <= 32'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_lsu_q <= owner_lsu_d;
      addr_q      <= addr_d;
      wen_q       <= wen_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  assign ifu_req_ready_o  = accept && !grant_lsu;
  assign lsu_req_ready_o  = accept && grant_lsu;
  assign mem_addr_o       = addr_q;
  assign mem_wen_o        = wen_q;
  assign mem_wdata_o      = wdata_q;
  assign mem_wmask_o      = wmask_q;
  assign ifu_resp_valid_o = (state_q == S_RESP) && !owner_lsu_q;
  assign lsu_resp_valid_o = (state_q == S_RESP) && owner_lsu_q;
  assign ifu_rdata_o      = rdata_q;
  assign lsu_rdata_o      = rdata_q;
  assign ifu_resp_err_o   = err_q;
  assign lsu_resp_err_o   = err_q;

endmodule
`default_nettype wire

// File: doc/ysyx_25030093_mem_arb.md
YSYX_25030093_MEM_ARB -- requirements
Module: ysyx_25030093_mem_arb

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255, cycles from REQ entry to forced error response; legal range 1..255.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-low.
REQ-004 ifu_req_valid  input  1  IFU read request; ifu_req_ready  output  1  IFU request accepted this cycle.
REQ-005 ifu_addr  input  32  IFU read address.
REQ-006 ifu_resp_valid  output  1  one-cycle IFU response pulse; ifu_rdata  output  32; ifu_resp_err  output  1.
REQ-007 lsu_req_valid  input  1; lsu_req_ready  output  1; lsu_addr  input  32; lsu_wen  input  1  1 = write.
REQ-008 lsu_wdata  input  32; lsu_wmask  input  4  byte enables.
REQ-009 lsu_resp_valid  output  1  one-cycle pulse; lsu_rdata  output  32; lsu_resp_err  output  1.
REQ-010 mem_req_valid  output  1; mem_req_ready  input  1; mem_addr  output  32; mem_wen  output  1; mem_wdata  output  32; mem_wmask  output  4.
REQ-011 mem_resp_valid  input  1; mem_rdata  input  32.

Function
REQ-012 FSM states IDLE, REQ, WAIT, RESP; one transaction in flight at a time.
REQ-013 IDLE: if any req_valid, winner's req_ready = 1 combinationally that cycle; addr/wen/wdata/wmask and owner latched; next state REQ.
REQ-014 req_ready SHALL be 0 in every state other than IDLE and 0 for the loser.
REQ-015 IFU transactions drive mem_wen = 0, mem_wdata = 0, mem_wmask = 0.
REQ-016 Fixed arbitration (ARB_RR_EN undefined): LSU wins when both valid.
REQ-017 REQ: mem_req_valid = 1 with latched fields stable until mem_req_ready sampled 1; next state WAIT.
REQ-018 WAIT: on mem_resp_valid = 1, capture mem_rdata, err = 0; next state RESP.
REQ-019 mem_resp_valid outside WAIT SHALL be ignored.
REQ-020 8-bit timeout counter cleared on IDLE->REQ, incremented each cycle in REQ and WAIT.
REQ-021 Counter reaching TIMEOUT_CYC in REQ or WAIT: rdata = 0, err = 1, mem_req_valid deasserted, next state RESP.
REQ-022 Same cycle mem_resp_valid and timeout in WAIT: response wins, err = 0.
REQ-023 RESP: owner's resp_valid = 1 for exactly one cycle with registered rdata/err; other master's resp_valid = 0; next state IDLE.
REQ-024 rdata/err outputs hold last value outside RESP; valid only qualifies them.
REQ-025 Latency: accept at T, mem_req_valid at T+1; if mem_req_ready at T+1 and mem_resp_valid at T+2, resp_valid at T+3; minimum 4 cycles per transaction.
REQ-026 A requester dropping req_valid after acceptance SHALL NOT affect the in-flight transaction.

Reset
REQ-027 rst low: state IDLE immediately, asynchronously; counter 0; all latched fields 0.
REQ-028 All outputs 0 during reset; any in-flight transaction is dropped with no response.
REQ-029 Round-robin last-grant register resets to LSU.

Configuration
REQ-030 Macro YSYX_25030093_ARB_RR_EN defined: round-robin; on tie, grant the master not granted last; last-grant updated at each acceptance.
REQ-031 Macro undefined: fixed LSU priority per REQ-016; no last-grant register.

Verification
REQ-032 Single IFU read 0x8000_0000, mem_req_ready = 1 immediately, mem_rdata 0x1234_5678 one cycle later -> ifu_resp_valid at T+3, ifu_rdata 0x1234_5678, err 0.
REQ-033 LSU write 0x8000_0010, wdata 0xDEAD_BEEF, wmask 0xF, mem_req_ready delayed 3 cycles -> mem fields stable all 3 cycles, lsu_resp_valid one pulse, ifu_resp_valid stays 0.
REQ-034 Both valid every cycle for 4 transactions -> fixed: LSU,LSU,LSU,LSU; RR_EN: IFU,LSU,IFU,LSU.
REQ-035 TIMEOUT_CYC = 8, mem_resp_valid never asserted -> resp_valid pulse 9 cycles after accept, rdata 0, err 1; spurious mem_resp_valid in IDLE ignored.
REQ-036 rst low during WAIT -> outputs 0 same cycle, no resp pulse after release, next request served normally.
